bus_cycle_sequencer: RTL and testbench

- Clocked bus-cycle controller for the 68k-family glue.
- Takes the decoded region selects (ROM, RAM, IO, expansion) and generates a registered DTACKn after a per-region wait-state count, or forwards the device's own acknowledge for the IO and expansion regions.
- Terminates unanswered cycles with BERRn via a watchdog, and tracks completed cycles to raise BOOT after the reset-vector fetches.
- Replaces the purely combinational DTACK/BERR generation in the glue CPLD.

---
 rtl/bus_cycle_sequencer_if.sv | 25 ++
 rtl/bus_cycle_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_sequencer_if.sv
// CPU-side bus signals for the 68k bus-cycle sequencer: strobe, region selects,
// device acknowledges, and the sequencer's DTACK/BERR/BOOT/ERRCNT responses.
interface bus_cycle_sequencer_if;
  logic       ASn;
  logic       ROMSELn;
  logic       RAMSELn;
  logic       IOSELn;
  logic       EXPSELn;
  logic       IODTACKn;
  logic       EXPDTACKn;
  logic       DTACKn;
  logic       BERRn;
  logic       BOOT;
  logic [7:0] ERRCNT;

  modport master (
    output ASn, ROMSELn, RAMSELn, IOSELn, EXPSELn, IODTACKn, EXPDTACKn,
    input  DTACKn, BERRn, BOOT, ERRCNT
  );

  modport slave (
    input  ASn, ROMSELn, RAMSELn, IOSELn, EXPSELn, IODTACKn, EXPDTACKn,
    output DTACKn, BERRn, BOOT, ERRCNT
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Registered DTACK/BERR generation for 68k bus cycles: per-region wait states,
// forwarded device acks, watchdog bus error, boot-overlay and bus-error counters.
module bus_cycle_sequencer #(
  parameter int ROM_WS      = 2,
  parameter int RAM_WS      = 0,
  parameter int WD_LIMIT    = 127,
  parameter int BOOT_CYCLES = 4
) (
  input logic                   CLK,
  input logic                   HWRST,
  bus_cycle_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0] RG_NONE = 3'd0;
  localparam logic [2:0] RG_ROM  = 3'd1;
  localparam logic [2:0] RG_RAM  = 3'd2;
  localparam logic [2:0] RG_IO   = 3'd3;
  localparam logic [2:0] RG_EXP  = 3'd4;

  localparam int WDW = $clog2(WD_LIMIT + 1);
  localparam int BCW = $clog2(BOOT_CYCLES + 1);

  localparam logic [3:0]     ROM_LOAD = (ROM_WS > 0) ? 4'(ROM_WS - 1) : 4'd0;
  localparam logic [3:0]     RAM_LOAD = (RAM_WS > 0) ? 4'(RAM_WS - 1) : 4'd0;
  localparam logic [WDW-1:0] WD_LAST  = WDW'(WD_LIMIT - 1);
  localparam logic [BCW-1:0] BC_MAX   = BCW'(BOOT_CYCLES);

  logic [1:0]     state_r,    state_s;
  logic [2:0]     region_r,   region_s, sel_region_s;
  logic [3:0]     wait_r,     wait_s;
  logic [WDW-1:0] wd_r,       wd_s;
  logic [BCW-1:0] boot_cnt_r, boot_cnt_s;
  logic           boot_r,     boot_s;
  logic [7:0]     err_cnt_r,  err_cnt_s;
  logic           dtack_n_r,  berr_n_r;
  logic           ack_s;

  // Region decode with fixed priority ROM > RAM > IO > EXP
  always_comb begin
    if (!bus.ROMSELn) begin
      sel_region_s = RG_ROM;
    end else if (!bus.RAMSELn) begin
      sel_region_s = RG_RAM;
    end else if (!bus.IOSELn) begin
      sel_region_s = RG_IO;
    end else if (!bus.EXPSELn) begin
      sel_region_s = RG_EXP;
    end else begin
      sel_region_s = RG_NONE;
    end
  end

  // Next-state, counters; only the latched region's acknowledge is looked at
  always_comb begin
    state_s    = state_r;
    region_s   = region_r;
    wait_s     = wait_r;
    wd_s       = wd_r;
    boot_cnt_s = boot_cnt_r;
    err_cnt_s  = err_cnt_r;
    case (region_r)
      RG_ROM, RG_RAM: ack_s = (wait_r == 4'd0);
      RG_IO:          ack_s = !bus.IODTACKn;
      RG_EXP:         ack_s = !bus.EXPDTACKn;
      default:        ack_s = 1'b0;
    endcase
    case (state_r)
      ST_IDLE: begin
        wd_s = '0;
        if (!bus.ASn) begin
          region_s = sel_region_s;
          if (sel_region_s == RG_ROM) begin
            state_s = (ROM_WS == 0) ? ST_ACK : ST_WAIT;
            wait_s  = ROM_LOAD;
          end else if (sel_region_s == RG_RAM) begin
            state_s = (RAM_WS == 0) ? ST_ACK : ST_WAIT;
            wait_s  = RAM_LOAD;
          end else begin
            state_s = ST_WAIT;
            wait_s  = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.ASn) begin
          state_s = ST_IDLE;
        end else if (ack_s) begin
          state_s = ST_ACK;
        end else if (wd_r == WD_LAST) begin
          state_s = ST_ERR;
        end else begin
          wd_s   = wd_r + 1'b1;
          wait_s = wait_r - 4'd1;
        end
      end
      ST_ACK: begin
        if (bus.ASn) begin
          state_s = ST_IDLE;
          if (boot_cnt_r != BC_MAX) begin
            boot_cnt_s = boot_cnt_r + 1'b1;
          end else begin
            boot_cnt_s = boot_cnt_r;
          end
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_ERR: begin
        if (bus.ASn) begin
          state_s = ST_IDLE;
          if (err_cnt_r != 8'hFF) begin
            err_cnt_s = err_cnt_r + 8'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
        end else begin
          state_s = ST_ERR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    boot_s = boot_r | (boot_cnt_s == BC_MAX);
  end

  // State and registered outputs; DTACKn/BERRn mirror the state being entered
  always_ff @(posedge CLK or posedge HWRST) begin
    if (HWRST) begin
      state_r    <= ST_IDLE;
      region_r   <= RG_NONE;
      wait_r     <= 4'd0;
      wd_r       <= '0;
      boot_cnt_r <= '0;
      boot_r     <= 1'b0;
      err_cnt_r  <= 8'd0;
      dtack_n_r  <= 1'b1;
      berr_n_r   <= 1'b1;
    end else begin
      state_r    <= state_s;
      region_r   <= region_s;
      wait_r     <= wait_s;
      wd_r       <= wd_s;
      boot_cnt_r <= boot_cnt_s;
      boot_r     <= boot_s;
      err_cnt_r  <= err_cnt_s;
      dtack_n_r  <= (state_s != ST_ACK);
      berr_n_r   <= (state_s != ST_ERR);
    end
  end

  assign bus.DTACKn = dtack_n_r;
  assign bus.BERRn  = berr_n_r;
  assign bus.BOOT   = boot_r;
  assign bus.ERRCNT = err_cnt_r;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: stimulus predicts each cycle's
// outcome from the bus rules; a negedge monitor checks the DUT's responses.
module tb_bus_cycle_sequencer;
  localparam int ROM_WS      = 2;
  localparam int RAM_WS      = 0;
  localparam int WD_LIMIT    = 127;
  localparam int BOOT_CYCLES = 4;

  logic CLK = 1'b0;
  logic HWRST = 1'b1;

  bus_cycle_sequencer_if bus();

  bus_cycle_sequencer #(
    .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .WD_LIMIT(WD_LIMIT), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .CLK(CLK),
    .HWRST(HWRST),
    .bus(bus)
  );

  typedef struct {
    bit is_err;
    int fire;
    int rel;
    int boot_before;
    int err_before;
    int boot_after;
    int err_after;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_boot_cnt = 0;
  int   m_err = 0;

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, cyc);
    end
  endtask

  // Outcome of a cycle from the bus rules: edges from E0 to the response and its kind.
  function automatic int exp_lat(input logic [3:0] sel, input int d, output bit err);
    err = 1'b0;
    if (!sel[0]) return ROM_WS;
    if (!sel[1]) return RAM_WS;
    if (!sel[2] || !sel[3]) begin
      if (d <= WD_LIMIT) return d;
      err = 1'b1;
      return WD_LIMIT;
    end
    err = 1'b1;
    return WD_LIMIT;
  endfunction

  task automatic goto_edge(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic idle_bus();
    bus.ASn = 1'b1; bus.ROMSELn = 1'b1; bus.RAMSELn = 1'b1;
    bus.IOSELn = 1'b1; bus.EXPSELn = 1'b1;
    bus.IODTACKn = 1'b1; bus.EXPDTACKn = 1'b1;
  endtask

  // sel is active-low {EXP,IO,RAM,ROM}; d = ack edge after E0; a>0 aborts at E0+a
  task automatic run_cycle(input logic [3:0] sel, input int d, input int a, input int h, input int gap);
    bit   err;
    bit   aborted;
    int   lat, e0, end_edge;
    exp_t e;
    lat = exp_lat(sel, d, err);
    e0 = cyc + 1;
    aborted = (a > 0) && (a <= lat);
    if (!aborted) begin
      e.is_err = err;
      e.fire = e0 + lat;
      e.rel = e0 + lat + h + 1;
      e.boot_before = (m_boot_cnt >= BOOT_CYCLES) ? 1 : 0;
      e.err_before = m_err;
      if (err) m_err = (m_err < 255) ? m_err + 1 : 255;
      else m_boot_cnt = (m_boot_cnt < BOOT_CYCLES) ? m_boot_cnt + 1 : BOOT_CYCLES;
      e.boot_after = (m_boot_cnt >= BOOT_CYCLES) ? 1 : 0;
      e.err_after = m_err;
      q.push_back(e);
    end
    end_edge = aborted ? e0 + a : e0 + lat + h + 1;
    bus.ROMSELn = sel[0]; bus.RAMSELn = sel[1];
    bus.IOSELn = sel[2]; bus.EXPSELn = sel[3];
    bus.IODTACKn = 1'b1; bus.EXPDTACKn = 1'b1;
    bus.ASn = 1'b0;
    while (cyc < end_edge - 1) begin
      @(negedge CLK);
      if (cyc + 1 >= e0 + d) begin
        bus.IODTACKn = 1'b0;
        bus.EXPDTACKn = 1'b0;
      end
    end
    idle_bus();
    goto_edge(end_edge + gap);
  endtask

  // Monitor: each DTACKn/BERRn assertion pops the next expected response
  initial begin
    logic pd, pb;
    pd = 1'b1; pb = 1'b1;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if ((pd && !bus.DTACKn) || (pb && !bus.BERRn)) begin
          if (q.size() == 0) begin
            chk("response_expected", 0, 1);
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            chk("resp_berr", int'(!bus.BERRn), int'(cur.is_err));
            chk("resp_dtack", int'(!bus.DTACKn), int'(!cur.is_err));
            chk("resp_edge", cyc, cur.fire);
            chk("boot_during", int'(bus.BOOT), cur.boot_before);
            chk("errcnt_during", int'(bus.ERRCNT), cur.err_before);
          end
        end else if (have_cur && bus.DTACKn && bus.BERRn) begin
          chk("release_edge", cyc, cur.rel);
          chk("boot_after", int'(bus.BOOT), cur.boot_after);
          chk("errcnt_after", int'(bus.ERRCNT), cur.err_after);
          have_cur = 1'b0;
        end
      end
      pd = bus.DTACKn;
      pb = bus.BERRn;
    end
  end

  task automatic random_cycles(input int n);
    logic [3:0] sel;
    int d, a, lat;
    bit err;
    for (int i = 0; i < n; i++) begin
      sel = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 135)) : int'($urandom_range(1, 12));
      lat = exp_lat(sel, d, err);
      a = ($urandom_range(0, 4) == 0 && lat > 0) ? int'($urandom_range(1, lat)) : 0;
      run_cycle(sel, d, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    idle_bus();
    repeat (2) @(negedge CLK);
    chk("rst_dtack", int'(bus.DTACKn), 1);
    chk("rst_berr", int'(bus.BERRn), 1);
    chk("rst_boot", int'(bus.BOOT), 0);
    chk("rst_errcnt", int'(bus.ERRCNT), 0);
    HWRST = 1'b0;
    @(negedge CLK);
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_cycle(4'b1110, 99, 0, i % 3, i % 2);
    run_cycle(4'b1101, 99, 0, 1, 0);
    run_cycle(4'b1011, 5, 0, 0, 1);
    run_cycle(4'b1111, 3, 0, 2, 1);
    run_cycle(4'b0111, WD_LIMIT, 0, 1, 0);
    run_cycle(4'b1100, 99, 0, 0, 0);
    run_cycle(4'b1110, 99, 1, 0, 0);
    run_cycle(4'b1011, 9, 4, 0, 1);
    random_cycles(30);

    mon_en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      int e0;
      e0 = cyc + 1;
      bus.ROMSELn = 1'b0;
      bus.ASn = 1'b0;
      goto_edge(e0 + ((s == 0) ? 0 : ROM_WS));
      chk("pre_reset_dtack", int'(bus.DTACKn), (s == 0) ? 1 : 0);
      #2 HWRST = 1'b1;
      #1;
      chk("async_rst_dtack", int'(bus.DTACKn), 1);
      chk("async_rst_berr", int'(bus.BERRn), 1);
      chk("async_rst_boot", int'(bus.BOOT), 0);
      chk("async_rst_errcnt", int'(bus.ERRCNT), 0);
      idle_bus();
      @(negedge CLK);
      HWRST = 1'b0;
      m_boot_cnt = 0;
      m_err = 0;
      @(negedge CLK);
      chk("post_reset_dtack", int'(bus.DTACKn), 1);
    end
    mon_en = 1'b1;
    random_cycles(10);
    run_cycle(4'b1111, 1, 0, 0, 2);

    goto_edge(cyc + 3);
    chk("queue_drained", q.size(), 0);
    chk("no_open_response", int'(have_cur), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
